// File: rtl/write_demux2.sv
// CPU write-path demultiplexer: captures one CPU write, fires a single-cycle
// one-hot load strobe (or an error pulse for protected/unmapped addresses), then acks.
module write_demux2 #(
  parameter int          NREG    = 21,
  parameter logic [31:0] WR_MASK = 32'h0007FFF0,
  parameter int          DATA_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              wr,
  input  logic [4:0]        address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_wr,
  output logic [NREG-1:0]   load_en,
  output logic              ack,
  output logic              wr_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          addr_q, addr_d;
  logic [DATA_W-1:0]   data_wr_q, data_wr_d;
  logic [NREG-1:0]     load_en_q, load_en_d;
  logic                ack_q, ack_d;
  logic                wr_err_q, wr_err_d;
  logic                req;

  // An address is loadable only if it exists in the register map and is not read-only.
  function automatic logic addr_writable(input logic [4:0] a);
    return (int'(a) < NREG) && WR_MASK[a];
  endfunction

  assign req = cs & wr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_wr_q <= '0;
      load_en_q <= '0;
      ack_q     <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_wr_q <= data_wr_d;
      load_en_q <= load_en_d;
      ack_q     <= ack_d;
      wr_err_q  <= wr_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = STROBE;
      STROBE:  state_d = ACK;
      ACK:     if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each value computed here appears one edge later.
  always_comb begin
    addr_d    = addr_q;
    data_wr_d = data_wr_q;
    load_en_d = '0;
    ack_d     = 1'b0;
    wr_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = address;
          data_wr_d = data_in;
        end
      end
      STROBE: begin
        if (addr_writable(addr_q)) load_en_d = NREG'(1) << addr_q;
        else                       wr_err_d  = 1'b1;
      end
      ACK:     ack_d = req;
      default: ;
    endcase
  end

  assign data_wr = data_wr_q;
  assign load_en = load_en_q;
  assign ack     = ack_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_write_demux2.sv
// Scoreboard bench for write_demux2: stimulus queues expected strobes/errors,
// a negedge monitor pops them whenever the DUT raises load_en or wr_err.
module tb_write_demux2;

  logic        clock;
  logic        reset;
  logic        cs;
  logic        wr;
  logic [4:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_wr;
  logic [20:0] load_en;
  logic        ack;
  logic        wr_err;

  typedef struct {
    logic [20:0] le;
    logic        err;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  int   nvec;
  int   nmis;

  write_demux2 dut (
    .clock   (clock),
    .reset   (reset),
    .cs      (cs),
    .wr      (wr),
    .address (address),
    .data_in (data_in),
    .data_wr (data_wr),
    .load_en (load_en),
    .ack     (ack),
    .wr_err  (wr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [20:0] le, input logic err, input logic [15:0] d);
    exp_t e;
    e.le  = le;
    e.err = err;
    e.d   = d;
    sb.push_back(e);
  endtask

  // Drives a write for 'hold' sampled edges (hold >= 3), then releases it.
  task automatic do_write(input logic [4:0] a, input logic [15:0] d, input int hold,
                          input logic [20:0] le, input logic err);
    cs = 1'b1; wr = 1'b1; address = a; data_in = d;
    push(le, err, d);
    cyc(1);
    cyc(1);
    chk("ack_during_strobe", {31'd0, ack}, 32'd0);
    cyc(1);
    chk("ack_rise", {31'd0, ack}, 32'd1);
    if (hold > 3) cyc(hold - 3);
    chk("ack_hold", {31'd0, ack}, 32'd1);
    chk("load_en_idle_in_ack", {11'd0, load_en}, 32'd0);
    cs = 1'b0; wr = 1'b0; address = ~a; data_in = ~d;
    cyc(1);
    chk("ack_release", {31'd0, ack}, 32'd0);
    chk("data_wr_hold", {16'd0, data_wr}, {16'd0, d});
  endtask

  // Monitor: every strobe or error pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (load_en !== 21'd0 || wr_err !== 1'b0) begin
        if (sb.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_strobe: got load_en=%0h wr_err=%0b expected none at %0t",
                   load_en, wr_err, $time);
        end else begin
          e = sb.pop_front();
          chk("strobe_load_en", {11'd0, load_en}, {11'd0, e.le});
          chk("strobe_wr_err", {31'd0, wr_err}, {31'd0, e.err});
          chk("strobe_data_wr", {16'd0, data_wr}, {16'd0, e.d});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0;
    nmis = 0;
    reset = 1'b1; cs = 1'b0; wr = 1'b0; address = 5'd0; data_in = 16'd0;
    cyc(2);
    chk("rst_data_wr", {16'd0, data_wr}, 32'd0);
    chk("rst_load_en", {11'd0, load_en}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
    reset = 1'b0;
    cyc(1);

    // Legal write held 5 cycles, then a long hold that must not re-strobe
    do_write(5'b01111, 16'h1234, 5, 21'h008000, 1'b0);
    cyc(1);
    do_write(5'b00101, 16'hC0DE, 10, 21'h000020, 1'b0);
    cyc(1);

    // Read-only and unmapped targets
    do_write(5'b10100, 16'hFFFF, 4, 21'h000000, 1'b1);
    do_write(5'b10011, 16'h0123, 3, 21'h000000, 1'b1);
    do_write(5'b00011, 16'h4567, 3, 21'h000000, 1'b1);
    do_write(5'b11111, 16'h0BAD, 3, 21'h000000, 1'b1);
    cyc(1);

    // wr without cs, then cs without wr: nothing happens
    cs = 1'b0; wr = 1'b1; address = 5'b01110; data_in = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("nocs_ack", {31'd0, ack}, 32'd0);
    end
    cs = 1'b1; wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("nowr_ack", {31'd0, ack}, 32'd0);
    end
    chk("nocs_data_wr", {16'd0, data_wr}, 32'h0000_0BAD);
    cs = 1'b0;
    cyc(1);

    // Back-to-back with a single released edge between them
    do_write(5'b10010, 16'hAAAA, 3, 21'h040000, 1'b0);
    do_write(5'b00100, 16'h5555, 3, 21'h000010, 1'b0);
    cyc(1);

    // Reset during the STROBE cycle discards the strobe
    cs = 1'b1; wr = 1'b1; address = 5'b00111; data_in = 16'h7777;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk("midrst_load_en", {11'd0, load_en}, 32'd0);
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    chk("midrst_wr_err", {31'd0, wr_err}, 32'd0);
    reset = 1'b0;
    do_write(5'b00111, 16'h7777, 4, 21'h000080, 1'b0);
    cyc(1);

    // Address/data changes after capture are ignored
    cs = 1'b1; wr = 1'b1; address = 5'b01101; data_in = 16'h0D0D;
    push(21'h002000, 1'b0, 16'h0D0D);
    cyc(1);
    address = 5'b00001; data_in = 16'hBEEF;
    cyc(1);
    cyc(1);
    chk("late_change_ack", {31'd0, ack}, 32'd1);
    cs = 1'b0; wr = 1'b0;
    cyc(1);
    chk("late_change_release", {31'd0, ack}, 32'd0);
    chk("late_change_data_wr", {16'd0, data_wr}, 32'h0000_0D0D);

    cyc(3);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
